// File: rtl/tlc_phase_arbiter.sv
// ---------------------------------------------------------------------------
// tlc_phase_arbiter
//   N-phase traffic light controller. Grants requesting phases round-robin,
//   ends a green on a vacancy gap or a contested max-green limit, then runs
//   a fixed yellow followed by an all-red interval before the next grant.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   phase_req      one request bit per phase
//   phase_light    per-phase light (red / yellow / green)
//   cur_phase      phase currently or most recently granted
//   green_active   high while a phase is green
//   preempt_req    (TLC_PREEMPT_EN only) preemption request
//   preempt_phase  (TLC_PREEMPT_EN only) phase to force green
//
// Optional feature macro: TLC_PREEMPT_EN
// ---------------------------------------------------------------------------

package light_package;
    typedef enum logic [1:0] {
        red    = 2'd0,
        yellow = 2'd1,
        green  = 2'd2
    } colors;
endpackage

// state    | meaning
// ---------+------------------------------------------------------------
// S_ALLRED | every phase red; arbitrate once the minimum all-red is met
// S_GREEN  | cur_phase green; gap and max-green timers running
// S_YELLOW | cur_phase yellow for a fixed number of cycles
module tlc_phase_arbiter #(
    parameter int NUM_PHASES    = 5,
    parameter int GAP_TIMEOUT   = 4,
    parameter int MAX_GREEN     = 9,
    parameter int YELLOW_CYCLES = 2,
    parameter int ALLRED_CYCLES = 1,
    parameter int CTR_W         = 8,
    localparam int PW           = $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PHASES-1:0] phase_req,
`ifdef TLC_PREEMPT_EN
    input  logic                  preempt_req,
    input  logic [PW-1:0]         preempt_phase,
`endif
    output light_package::colors  phase_light [NUM_PHASES],
    output logic [PW-1:0]         cur_phase,
    output logic                  green_active
);
    import light_package::*;

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      phase_nxt;
    logic [CTR_W-1:0]   gap_ctr, gap_nxt;
    logic [CTR_W-1:0]   max_ctr, max_nxt;
    logic [CTR_W-1:0]   dwell_ctr, dwell_nxt;
    logic [CTR_W-1:0]   dwell_sat_inc;

    logic               own, other;
    logic [NUM_PHASES-1:0] own_mask;
    logic               arb_found;
    logic [PW-1:0]      arb_winner;

    logic               pre_valid;
    logic [PW-1:0]      pre_phase;

`ifdef TLC_PREEMPT_EN
    assign pre_valid = preempt_req && ({1'b0, preempt_phase} < (PW+1)'(NUM_PHASES));
    assign pre_phase = preempt_phase;
`else
    assign pre_valid = 1'b0;
    assign pre_phase = '0;
`endif

    assign own_mask      = NUM_PHASES'(1) << cur_phase;
    assign own           = phase_req[cur_phase];
    assign other         = |(phase_req & ~own_mask);
    assign dwell_sat_inc = (dwell_ctr == '1) ? dwell_ctr : dwell_ctr + CTR_W'(1);

    // Round-robin search starting just after the last granted phase and
    // ending on that phase itself, so a lone requester can be re-granted.
    always_comb begin
        arb_found  = 1'b0;
        arb_winner = cur_phase;
        for (int i = 1; i <= NUM_PHASES; i++) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(cur_phase) + i) % NUM_PHASES);
            if (!arb_found && phase_req[idx]) begin
                arb_found  = 1'b1;
                arb_winner = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_ALLRED;
            cur_phase <= PW'(NUM_PHASES - 1);
            gap_ctr   <= '0;
            max_ctr   <= '0;
            dwell_ctr <= '0;
        end else begin
            state     <= state_nxt;
            cur_phase <= phase_nxt;
            gap_ctr   <= gap_nxt;
            max_ctr   <= max_nxt;
            dwell_ctr <= dwell_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = cur_phase;
        gap_nxt   = gap_ctr;
        max_nxt   = max_ctr;
        dwell_nxt = dwell_ctr;
        case (state)
            S_ALLRED: begin
                dwell_nxt = dwell_sat_inc;
                if (dwell_ctr >= CTR_W'(ALLRED_CYCLES - 1)) begin
                    if (pre_valid) begin
                        state_nxt = S_GREEN;
                        phase_nxt = pre_phase;
                        gap_nxt   = '0;
                        max_nxt   = '0;
                    end else if (arb_found) begin
                        state_nxt = S_GREEN;
                        phase_nxt = arb_winner;
                        gap_nxt   = '0;
                        max_nxt   = '0;
                    end
                end
            end
            S_GREEN: begin
                if (pre_valid && (cur_phase != pre_phase)) begin
                    state_nxt = S_YELLOW;
                    dwell_nxt = '0;
                end else if (pre_valid) begin
                    gap_nxt = '0;
                    max_nxt = '0;
                end else if ((gap_ctr == CTR_W'(GAP_TIMEOUT - 1)) ||
                             (max_ctr == CTR_W'(MAX_GREEN - 1))) begin
                    state_nxt = S_YELLOW;
                    dwell_nxt = '0;
                end else begin
                    gap_nxt = own ? '0 : gap_ctr + CTR_W'(1);
                    max_nxt = other ? max_ctr + CTR_W'(1) : max_ctr;
                end
            end
            S_YELLOW: begin
                if (dwell_ctr == CTR_W'(YELLOW_CYCLES - 1)) begin
                    state_nxt = S_ALLRED;
                    dwell_nxt = '0;
                end else begin
                    dwell_nxt = dwell_ctr + CTR_W'(1);
                end
            end
            default: begin
                state_nxt = S_ALLRED;
                dwell_nxt = '0;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_PHASES; i++) begin
            phase_light[i] = red;
            if (PW'(i) == cur_phase) begin
                if (state == S_GREEN)
                    phase_light[i] = green;
                else if (state == S_YELLOW)
                    phase_light[i] = yellow;
            end
        end
    end

    assign green_active = (state == S_GREEN);

endmodule
